// File: rtl/updown_counter_cascade.sv
// updown_counter_cascade
//   Cascadable modulo-N up/down/load counter. State updates on the falling
//   clock edge; rst is an asynchronous, active-low clear.
//   Stages chain through cin/cout, and mo forwards the mode to the next stage.
//   Build macro SAT_MODE_EN: counting saturates at the terminal value
//   instead of wrapping. Carry, borrow and wrap reporting are unchanged.
module updown_counter_cascade #(
  parameter int WIDTH  = 8,
  parameter int MODULO = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [WIDTH-1:0] pin,
  input  logic [1:0]       m,
  input  logic             clr,
  output logic [WIDTH-1:0] fout,
  output logic             cout,
  output logic [1:0]       mo,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] M_HOLD = 2'd0;
  localparam logic [1:0] M_UP   = 2'd1;
  localparam logic [1:0] M_DOWN = 2'd2;
  localparam logic [1:0] M_LOAD = 2'd3;

  logic [WIDTH-1:0] r_fout;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next_fout;
  logic [WIDTH-1:0] w_load_val;
  logic             w_next_wrap;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_term_hit;

  assign w_at_max  = (r_fout == MAX_V);
  assign w_at_zero = (r_fout == ZERO_V);

  // A full binary range can never hold an out-of-range load value, so the clamp is only built for a reduced modulus.
  if (MODULO < (2**WIDTH)) begin : g_clamp
    assign w_load_val = (pin > MAX_V) ? MAX_V : pin;
  end else begin : g_no_clamp
    assign w_load_val = pin;
  end

  // Terminal-value detection: carry when counting up at MAX, borrow when counting down at 0
  always_comb begin
    w_term_hit = 1'b0;
    case (m)
      M_UP:    w_term_hit = cin & w_at_max;
      M_DOWN:  w_term_hit = cin & w_at_zero;
      default: w_term_hit = 1'b0;
    endcase
  end

  // Next count: hold, gated up/down step with wrap or saturation, or clamped load
  always_comb begin
    w_next_fout = r_fout;
    case (m)
      M_HOLD: w_next_fout = r_fout;
      M_UP: begin
        if (!cin) begin
          w_next_fout = r_fout;
        end else if (w_at_max) begin
`ifdef SAT_MODE_EN
          w_next_fout = MAX_V;
`else
          w_next_fout = ZERO_V;
`endif
        end else begin
          w_next_fout = r_fout + ONE_V;
        end
      end
      M_DOWN: begin
        if (!cin) begin
          w_next_fout = r_fout;
        end else if (w_at_zero) begin
`ifdef SAT_MODE_EN
          w_next_fout = ZERO_V;
`else
          w_next_fout = MAX_V;
`endif
        end else begin
          w_next_fout = r_fout - ONE_V;
        end
      end
      M_LOAD:  w_next_fout = w_load_val;
      default: w_next_fout = r_fout;
    endcase
  end

  // Sticky wrap flag: a terminal hit takes priority over a coincident clear
  always_comb begin
    w_next_wrap = r_wrap;
    if (w_term_hit) begin
      w_next_wrap = 1'b1;
    end else if (clr) begin
      w_next_wrap = 1'b0;
    end else begin
      w_next_wrap = r_wrap;
    end
  end

  // State register: falling-edge update, asynchronous active-low clear
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_fout <= ZERO_V;
      r_wrap <= 1'b0;
    end else begin
      r_fout <= w_next_fout;
      r_wrap <= w_next_wrap;
    end
  end

  assign fout = r_fout;
  assign wrap = r_wrap;
  assign cout = w_term_hit;
  assign mo   = m;

endmodule

// File: tb/tb_updown_counter_cascade.sv
// Bench for updown_counter_cascade: a MODULO=10 stage, a MODULO=256 stage and
// a two-stage MODULO=10 chain share one stimulus stream. Expected values come
// from a behavioural model and pass through scoreboard queues.
`timescale 1ns/1ps
module tb_updown_counter_cascade;

`ifdef SAT_MODE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cin;
  logic       clr;
  logic [1:0] m;
  logic [7:0] pin;

  logic [7:0] a_fout, s_fout, lo_fout, hi_fout;
  logic       a_cout, s_cout, lo_cout, hi_cout;
  logic [1:0] a_mo, s_mo, lo_mo, hi_mo;
  logic       a_wrap, s_wrap, lo_wrap, hi_wrap;

  int n_tests;
  int n_fail;
  int hi_events;

  int a_cnt, s_cnt, lo_cnt, hi_cnt;
  bit a_wr, s_wr, lo_wr, hi_wr;

  logic [31:0] q_a[$];
  logic [31:0] q_s[$];
  logic [31:0] q_c[$];

  updown_counter_cascade #(.WIDTH(8), .MODULO(10)) u_a (
    .clk(clk), .rst(rst), .cin(cin), .pin(pin), .m(m), .clr(clr),
    .fout(a_fout), .cout(a_cout), .mo(a_mo), .wrap(a_wrap));

  updown_counter_cascade #(.WIDTH(8), .MODULO(256)) u_s (
    .clk(clk), .rst(rst), .cin(cin), .pin(pin), .m(m), .clr(clr),
    .fout(s_fout), .cout(s_cout), .mo(s_mo), .wrap(s_wrap));

  updown_counter_cascade #(.WIDTH(8), .MODULO(10)) u_lo (
    .clk(clk), .rst(rst), .cin(cin), .pin(pin), .m(m), .clr(clr),
    .fout(lo_fout), .cout(lo_cout), .mo(lo_mo), .wrap(lo_wrap));

  updown_counter_cascade #(.WIDTH(8), .MODULO(10)) u_hi (
    .clk(clk), .rst(rst), .cin(lo_cout), .pin(pin), .m(lo_mo), .clr(clr),
    .fout(hi_fout), .cout(hi_cout), .mo(hi_mo), .wrap(hi_wrap));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_term(int c, logic [1:0] md, logic ci, int mod);
    return ci && ((md == 2'd1 && c == mod - 1) || (md == 2'd2 && c == 0));
  endfunction

  function automatic int mdl_next(int c, logic [1:0] md, logic ci, int p, int mod);
    int r;
    r = c;
    if (md == 2'd3) r = (p > mod - 1) ? mod - 1 : p;
    else if (md == 2'd1 && ci) r = (c == mod - 1) ? (SAT ? c : 0) : c + 1;
    else if (md == 2'd2 && ci) r = (c == 0) ? (SAT ? 0 : mod - 1) : c - 1;
    return r;
  endfunction

  task automatic model_reset();
    a_cnt = 0; s_cnt = 0; lo_cnt = 0; hi_cnt = 0;
    a_wr = 1'b0; s_wr = 1'b0; lo_wr = 1'b0; hi_wr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " a"},     32'({a_wrap, a_fout}), 32'd0);
    check({tag, " s"},     32'({s_wrap, s_fout}), 32'd0);
    check({tag, " chain"}, 32'({hi_wrap, lo_wrap, hi_fout, lo_fout}), 32'd0);
  endtask

  // One directed step: drive, check zero-latency outputs, push expectations,
  // take one falling edge, then pop and compare registered outputs.
  task automatic step(input logic [1:0] md, input logic ci, input logic [7:0] p,
                      input logic cl, input string tag);
    bit e_a_c, e_s_c, e_lo_c, e_hi_c;
    m = md; cin = ci; pin = p; clr = cl;
    #1;
    e_a_c  = mdl_term(a_cnt, md, ci, 10);
    e_s_c  = mdl_term(s_cnt, md, ci, 256);
    e_lo_c = mdl_term(lo_cnt, md, ci, 10);
    e_hi_c = mdl_term(hi_cnt, md, e_lo_c, 10);
    check({tag, " a.mo/cout"},   32'({a_mo, a_cout}), 32'({md, e_a_c}));
    check({tag, " s.cout"},      32'(s_cout), 32'(e_s_c));
    check({tag, " chain.cout"},  32'({hi_mo, hi_cout, lo_cout}), 32'({md, e_hi_c, e_lo_c}));
    if (hi_cout === 1'b1) hi_events++;
    a_wr  = e_a_c  | (a_wr  & ~cl);
    s_wr  = e_s_c  | (s_wr  & ~cl);
    lo_wr = e_lo_c | (lo_wr & ~cl);
    hi_wr = e_hi_c | (hi_wr & ~cl);
    a_cnt  = mdl_next(a_cnt,  md, ci,     int'(p), 10);
    s_cnt  = mdl_next(s_cnt,  md, ci,     int'(p), 256);
    hi_cnt = mdl_next(hi_cnt, md, e_lo_c, int'(p), 10);
    lo_cnt = mdl_next(lo_cnt, md, ci,     int'(p), 10);
    q_a.push_back(32'({a_wr, 8'(a_cnt)}));
    q_s.push_back(32'({s_wr, 8'(s_cnt)}));
    q_c.push_back(32'({hi_wr, lo_wr, 8'(hi_cnt), 8'(lo_cnt)}));
    @(negedge clk);
    #1;
    check({tag, " a"},     32'({a_wrap, a_fout}), q_a.pop_front());
    check({tag, " s"},     32'({s_wrap, s_fout}), q_s.pop_front());
    check({tag, " chain"}, 32'({hi_wrap, lo_wrap, hi_fout, lo_fout}), q_c.pop_front());
  endtask

  initial begin
    n_tests = 0; n_fail = 0; hi_events = 0;
    rst = 1'b0; cin = 1'b0; clr = 1'b0; m = 2'd0; pin = 8'd0;
    model_reset();
    @(negedge clk); #1;
    chk_zero("reset_init");
    rst = 1'b1;

    // Count to 7, then assert reset between edges
    step(2'd3, 1'b0, 8'd5, 1'b0, "load5");
    step(2'd1, 1'b1, 8'd0, 1'b0, "up6");
    step(2'd1, 1'b1, 8'd0, 1'b0, "up7");
    check("pre_reset a", 32'(a_fout), 32'd7);
    rst = 1'b0;
    #1;
    chk_zero("reset_async");
    m = 2'd1; cin = 1'b1;
    @(negedge clk); #1;
    chk_zero("reset_held");
    rst = 1'b1;
    model_reset();
    repeat (3) step(2'd1, 1'b1, 8'd0, 1'b0, "up_after_reset");
    check("three_edges a", 32'(a_fout), 32'd3);

    // Up wrap, clear, and set-versus-clear priority
    step(2'd3, 1'b0, 8'd9, 1'b0, "load9");
    step(2'd1, 1'b1, 8'd0, 1'b0, "up_wrap");
`ifndef SAT_MODE_EN
    check("up_wrap explicit a", 32'({a_wrap, a_fout}), 32'h100);
`endif
    step(2'd0, 1'b0, 8'd0, 1'b1, "clr");
    step(2'd3, 1'b0, 8'd9, 1'b0, "load9b");
    step(2'd1, 1'b1, 8'd0, 1'b1, "set_vs_clr");
    step(2'd0, 1'b0, 8'd0, 1'b1, "clr2");

    // Down borrow, then cin gating
    step(2'd3, 1'b0, 8'd0, 1'b0, "load0");
    step(2'd2, 1'b1, 8'd0, 1'b0, "down_borrow");
    step(2'd2, 1'b0, 8'd0, 1'b0, "down_hold");
    step(2'd1, 1'b0, 8'd0, 1'b0, "up_hold");

    // Load clamp boundaries; load ignores cin
    step(2'd0, 1'b0, 8'd0, 1'b1, "clr3");
    step(2'd3, 1'b0, 8'd200, 1'b0, "load200");
    step(2'd3, 1'b1, 8'd5, 1'b0, "load5_cin");
    step(2'd3, 1'b0, 8'd10, 1'b0, "load10");
    step(2'd3, 1'b1, 8'd9, 1'b0, "load9_cin");
    step(2'd0, 1'b1, 8'd0, 1'b0, "hold_cin");

    // Full-range stage at its extremes
    step(2'd3, 1'b0, 8'd255, 1'b0, "load255");
    repeat (3) step(2'd1, 1'b1, 8'd0, 1'b0, "s_up_top");
    step(2'd3, 1'b0, 8'd0, 1'b1, "load0_clr");
    repeat (2) step(2'd2, 1'b1, 8'd0, 1'b0, "s_down_bottom");

    // Random mix
    for (int i = 0; i < 20; i++) begin
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "random");
    end

    // Two-stage chain: 100 up edges from 00, then one down edge
    step(2'd0, 1'b0, 8'd0, 1'b1, "casc_clr");
    step(2'd3, 1'b0, 8'd0, 1'b0, "casc_load00");
    hi_events = 0;
    repeat (100) step(2'd1, 1'b1, 8'd0, 1'b0, "casc_up");
`ifndef SAT_MODE_EN
    check("casc_hi_wrap_count", 32'(hi_events), 32'd1);
    check("casc_up_final", 32'({hi_wrap, hi_fout, lo_fout}), 32'h10000);
`endif
    step(2'd0, 1'b0, 8'd0, 1'b1, "casc_clr2");
    step(2'd2, 1'b1, 8'd0, 1'b0, "casc_down");
`ifndef SAT_MODE_EN
    check("casc_down_final", 32'({hi_fout, lo_fout}), 32'h0909);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
